// File: rtl/register_file_param.sv
// Purpose : parametrised 2R/1W register file (R0 = 0) with a per-register busy scoreboard.
// Latency : reads 0 cycles; writes and busy changes visible the cycle after the edge
//           (with REGFILE_BYPASS_EN, write data is forwarded to the read ports in the write cycle).
// Backpressure: none; writes and reserves are single-cycle strobes that are always accepted.
module register_file_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  ReserveEn,
    input  logic [ADDR_WIDTH-1:0] ReserveRegister,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadBusy1,
    output logic                  ReadBusy2,
    output logic                  AnyBusy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busyNext;
    logic [DEPTH-1:0]      writeDec;
    logic [DEPTH-1:0]      reserveDec;
    logic                  writeHit;
    logic                  reserveHit;
    logic [DATA_WIDTH-1:0] storedData1;
    logic [DATA_WIDTH-1:0] storedData2;

    // Index 0 is the hardwired zero register: strobes aimed at it are dropped here.
    assign writeHit   = RegWrite  && (WriteRegister   != '0);
    assign reserveHit = ReserveEn && (ReserveRegister != '0);

    // One-hot decode of the write and reserve targets.
    always_comb begin
        writeDec   = '0;
        reserveDec = '0;
        if (writeHit) begin
            writeDec[WriteRegister] = 1'b1;
        end
        if (reserveHit) begin
            reserveDec[ReserveRegister] = 1'b1;
        end
    end

    // A write retires the producer; a reserve on the same edge re-arms it, so reserve wins.
    always_comb begin
        busyNext = (busy & ~writeDec) | reserveDec;
    end

    // Register storage; R0 is cleared at reset and never written afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Busy scoreboard; reset discards every outstanding reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // Stored read values, with optional same-cycle forwarding of the write port.
    always_comb begin
        storedData1 = regs[ReadRegister1];
        storedData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (writeHit && (WriteRegister == ReadRegister1)) begin
            storedData1 = WriteData;
        end
        if (writeHit && (WriteRegister == ReadRegister2)) begin
            storedData2 = WriteData;
        end
`endif
    end

    // Output stage: R0 reads as zero, and reset forces every output low (also masks the bypass).
    always_comb begin
        ReadData1 = storedData1;
        ReadData2 = storedData2;
        ReadBusy1 = busy[ReadRegister1];
        ReadBusy2 = busy[ReadRegister2];
        AnyBusy   = |busy;
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
            ReadBusy1 = 1'b0;
        end
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
            ReadBusy2 = 1'b0;
        end
        if (rst) begin
            ReadData1 = '0;
            ReadData2 = '0;
            ReadBusy1 = 1'b0;
            ReadBusy2 = 1'b0;
            AnyBusy   = 1'b0;
        end
    end

endmodule
